// File: rtl/snn_pkg.sv
// Shared SNN definitions: FSM state codes, default decoder sizing and the
// saturating-increment helper also used by the spike encoder.
package snn_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    localparam int DEFAULT_WINDOW = 64;
    localparam int DEFAULT_CNT_W  = 8;

    // Adds inc to value but never goes past max_val, so counters cannot wrap.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic        inc,
                                            input logic [31:0] max_val);
        if (inc && (value < max_val)) begin
            sat_inc = value + 32'd1;
        end else begin
            sat_inc = value;
        end
    endfunction

endpackage

// File: rtl/snn_spike_channel_counter.sv
// Per-channel saturating spike counter. With SNN_DECODER_EDGE_COUNT_EN defined
// only rising edges are counted; otherwise every high sample is counted.
module snn_spike_channel_counter
    import snn_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             count_en,
    input  logic             restart,
    input  logic             spike,
    output logic [CNT_W-1:0] count_next
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] count_r;
    logic             hit_s;

`ifdef SNN_DECODER_EDGE_COUNT_EN
    logic prev_r;

    // Previous sample survives window restarts so an edge spanning the boundary counts once.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prev_r <= 1'b0;
        end else if (count_en) begin
            prev_r <= spike;
        end else begin
            prev_r <= prev_r;
        end
    end

    always_comb begin
        hit_s = spike & ~prev_r;
    end
`else
    always_comb begin
        hit_s = spike;
    end
`endif

    // count_next includes the current sample so the top can capture the last window cycle.
    always_comb begin
        if (count_en) begin
            count_next = CNT_W'(sat_inc(32'(count_r), hit_s, CNT_MAX));
        end else begin
            count_next = count_r;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear || restart) begin
            count_r <= {CNT_W{1'b0}};
        end else if (count_en) begin
            count_r <= count_next;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/snn_spike_rate_decoder.sv
// Spike-rate decoder: accumulates per-channel spike counts over WINDOW cycles and
// presents counts plus argmax winner via valid/ready. Option: SNN_DECODER_EDGE_COUNT_EN.
module snn_spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         spikes_in,
    output logic [NUM_CH*CNT_W-1:0]   out_counts,
    output logic [$clog2(NUM_CH)-1:0] out_winner,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overrun
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    logic [0:0]               state_r;
    logic [WIN_W-1:0]         wcnt_r;
    logic                     count_en_s;
    logic                     clear_s;
    logic                     win_end_s;
    logic [CNT_W-1:0]         ch_next_s [NUM_CH];
    logic [NUM_CH*CNT_W-1:0]  final_counts_s;
    logic [IDX_W-1:0]         best_idx_s;
    logic [CNT_W-1:0]         best_cnt_s;

    always_comb begin
        count_en_s = (state_r == ST_ACCUM) && enable;
        clear_s    = (state_r == ST_IDLE) || !enable;
        win_end_s  = count_en_s && (wcnt_r == WIN_LAST);
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            snn_spike_channel_counter #(.CNT_W(CNT_W)) u_counter (
                .clk        (clk),
                .reset      (reset),
                .clear      (clear_s),
                .count_en   (count_en_s),
                .restart    (win_end_s),
                .spike      (spikes_in[g]),
                .count_next (ch_next_s[g])
            );
            assign final_counts_s[g*CNT_W +: CNT_W] = ch_next_s[g];
        end
    endgenerate

    // Strictly-greater comparison keeps the lowest index on ties.
    always_comb begin
        best_idx_s = {IDX_W{1'b0}};
        best_cnt_s = ch_next_s[0];
        for (int i = 1; i < NUM_CH; i++) begin
            if (ch_next_s[i] > best_cnt_s) begin
                best_cnt_s = ch_next_s[i];
                best_idx_s = IDX_W'(i);
            end else begin
                best_cnt_s = best_cnt_s;
                best_idx_s = best_idx_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            wcnt_r  <= {WIN_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= enable ? ST_ACCUM : ST_IDLE;
                    wcnt_r  <= {WIN_W{1'b0}};
                end
                ST_ACCUM: begin
                    if (!enable) begin
                        state_r <= ST_IDLE;
                        wcnt_r  <= {WIN_W{1'b0}};
                    end else if (wcnt_r == WIN_LAST) begin
                        state_r <= ST_ACCUM;
                        wcnt_r  <= {WIN_W{1'b0}};
                    end else begin
                        state_r <= ST_ACCUM;
                        wcnt_r  <= wcnt_r + WIN_W'(1'b1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    wcnt_r  <= {WIN_W{1'b0}};
                end
            endcase
        end
    end

    // A finished window loads only if the output slot is free or being drained this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_counts <= {(NUM_CH*CNT_W){1'b0}};
            out_winner <= {IDX_W{1'b0}};
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else if (win_end_s && (!out_valid || out_ready)) begin
            out_counts <= final_counts_s;
            out_winner <= best_idx_s;
            out_valid  <= 1'b1;
        end else if (win_end_s) begin
            overrun    <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end else begin
            out_valid  <= out_valid;
        end
    end

endmodule
